ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on posedge clk.
REQ-002 SHALL have port rst_n, input, 1, reset that is synchronous and active-low.
REQ-003 SHALL have port start, input, 1, one-cycle request to begin a burst; sampled only in IDLE.
REQ-004 SHALL have port base_addr, input, 16, first RAM address of the burst; captured on accepted start.
REQ-005 SHALL have port len, input, 16, byte count; captured on accepted start.
REQ-006 SHALL have port ram_addr, output, 16, read address to a sync RAM port (registered output, 1-cycle latency, no read enable).
REQ-007 SHALL have port ram_q, input, 8, RAM read data for the address presented one cycle earlier.
REQ-008 SHALL have ports m_data (output, 8) and m_valid (output, 1), the output byte stream.
REQ-009 SHALL have port m_ready, input, 1, sink accept; a byte transfers when m_valid && m_ready.
REQ-010 SHALL have port m_last, output, 1, high with the final byte of a burst.
REQ-011 SHALL have ports busy (output, 1; high outside IDLE) and done (output, 1; one-cycle pulse at burst end).

Function
REQ-012 SHALL implement FSM IDLE -> RUN on start, RUN -> DRAIN when all len reads are issued, DRAIN -> DONE when the FIFO is empty and no read is in flight, DONE -> IDLE unconditionally.
REQ-013 SHALL, on start with len==0, go IDLE -> DONE directly: done pulses one cycle later and no byte is emitted.
REQ-014 SHALL ignore start in RUN, DRAIN and DONE.
REQ-015 SHALL issue one read per cycle in RUN only when (fifo_count + inflight - pop_this_cycle) < 2, and SHALL hold ram_addr when not issuing.
REQ-016 SHALL increment ram_addr by 1 per issued read, wrapping modulo 2^16 (0xFFFF -> 0x0000).
REQ-017 SHALL capture ram_q into a 2-entry FIFO on the cycle after each issued read.
REQ-018 SHALL drive m_data and m_valid from the FIFO head; m_data SHALL remain stable while m_valid && !m_ready.
REQ-019 SHALL achieve one byte per cycle when m_ready is held high, with a first-byte latency of 2 cycles from start.
REQ-020 SHALL assert m_last only with the byte whose index equals len-1.
REQ-021 SHALL support a simultaneous FIFO push and pop with no change in count and no data loss.
REQ-022 SHALL never overflow the FIFO under any m_ready pattern.

Reset
REQ-023 SHALL, while rst_n==0 at a clock edge, set state=IDLE, ram_addr=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0, empty the FIFO, clear the in-flight flag and set remaining count=0.
REQ-024 SHALL, on reset asserted mid-burst, abandon the burst with no done pulse, and drive m_valid=0 on the following cycle.

Configuration
REQ-025 SHALL, when RAM_STREAM_READER_CHECKSUM_EN is defined, add output checksum (16 bits): cleared on accepted start, adding each transferred byte modulo 2^16, valid from the done pulse until the next start.
REQ-026 SHALL, when RAM_STREAM_READER_CHECKSUM_EN is undefined, have no checksum port and no checksum logic.

Structure
REQ-027 SHALL place the FSM state enum, ADDR_W=16, DATA_W=8 and FIFO_DEPTH=2 in the shared package ram_stream_pkg.
REQ-028 SHALL implement the 2-entry FIFO as sub-module ram_stream_fifo (push, pop, data, full, empty, count).

Verification
REQ-029 SHALL cover: RAM preloaded with bytes equal to their address, base=0x0010, len=4, m_ready=1 -> bytes 0x10,0x11,0x12,0x13 on consecutive cycles, m_last on 0x13, done one cycle after.
REQ-030 SHALL cover: base=0xFFFE, len=4 -> ram_addr sequence 0xFFFE,0xFFFF,0x0000,0x0001; data 0xFE,0xFF,0x00,0x01.
REQ-031 SHALL cover: len=8 with m_ready toggling 1,0,0,1 repeating -> all 8 bytes in order, none dropped or duplicated, m_data stable during stalls.
REQ-032 SHALL cover: len=0 -> done pulse, m_valid never high, busy high for exactly 1 cycle.
REQ-033 SHALL cover: rst_n low for 1 cycle after the 3rd byte of a len=10 burst -> m_valid=0 next cycle, state IDLE, no done; a new start then works normally.
REQ-034 SHALL cover: with RAM_STREAM_READER_CHECKSUM_EN defined, bytes 0xFF x 3 -> checksum=0x02FD at done.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// rtl/ram_stream_reader_pkg.sv - shared widths, FIFO sizing and FSM encoding for ram_stream_reader
package ram_stream_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 8;
    localparam int LEN_W      = 16;
    localparam int FIFO_DEPTH = 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/ram_stream_reader_if.sv
// rtl/ram_stream_reader_if.sv - output byte stream bundle between reader and sink
interface ram_stream_reader_if;

    logic [ram_stream_pkg::DATA_W-1:0] m_data;
    logic                              m_valid;
    logic                              m_ready;
    logic                              m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/ram_stream_reader_fifo.sv
// rtl/ram_stream_reader_fifo.sv - small FIFO buffering RAM read data ahead of the stream sink
module ram_stream_fifo
    import ram_stream_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is allowed only when the head leaves on the same edge
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign full    = (count == CNT_W'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign data    = mem[rd_ptr];

    // Storage, pointers and occupancy; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ram_stream_reader.sv
// rtl/ram_stream_reader.sv - burst reader from a sync RAM to a byte stream; checksum output under RAM_STREAM_READER_CHECKSUM_EN
module ram_stream_reader
    import ram_stream_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [LEN_W-1:0]   len,
    output logic [ADDR_W-1:0]  ram_addr,
    input  logic [DATA_W-1:0]  ram_q,
    ram_stream_reader_if.master m,
    output logic               busy,
    output logic               done
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [15:0]        checksum
`endif
);

    state_t            state;
    logic [LEN_W-1:0]  rd_left;
    logic [LEN_W-1:0]  out_left;
    logic              inflight;
    logic              accept;
    logic              issue;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic [DATA_W-1:0] fifo_data;

    assign accept = (state == ST_IDLE) && start;
    assign pop    = !fifo_empty && m.m_ready;

    // A read may go out only if the FIFO can still absorb it after this edge's pop
    assign issue = (state == ST_RUN) && !fifo_full &&
                   ((3'(fifo_count) + 3'(inflight) - 3'(pop)) < 3'd2);

    assign m.m_data  = fifo_data;
    assign m.m_valid = !fifo_empty;
    assign m.m_last  = !fifo_empty && (out_left == LEN_W'(1));
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    ram_stream_fifo u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight),
        .pop       (pop),
        .push_data (ram_q),
        .data      (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Burst control: address generation, read tracking and state sequencing
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ram_addr <= '0;
            inflight <= 1'b0;
            rd_left  <= '0;
            out_left <= '0;
        end else begin
            inflight <= issue;
            if (pop && (out_left != '0)) begin
                out_left <= out_left - LEN_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ram_addr <= base_addr;
                        rd_left  <= len;
                        out_left <= len;
                        state    <= (len == '0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        rd_left <= rd_left - LEN_W'(1);
                        // The final read leaves ram_addr on the last address of the burst
                        if (rd_left == LEN_W'(1)) begin
                            state <= ST_DRAIN;
                        end else begin
                            ram_addr <= ram_addr + ADDR_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Leave as soon as the last byte is handed over, so done follows it directly
                    if (!inflight && (fifo_empty || ((fifo_count == CNT_W'(1)) && pop))) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef RAM_STREAM_READER_CHECKSUM_EN
    // Running 16-bit sum of every byte the sink accepts in the current burst
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + 16'(m.m_data);
        end
    end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb/tb_ram_stream_reader.sv - directed scoreboard bench for ram_stream_reader
module tb_ram_stream_reader;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] base_addr;
    logic [15:0] len;
    logic [15:0] ram_addr;
    logic [7:0]  ram_q;
    logic        busy;
    logic        done;
`ifdef RAM_STREAM_READER_CHECKSUM_EN
    logic [15:0] checksum;
`endif

    ram_stream_reader_if s_if ();

    ram_stream_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .ram_addr  (ram_addr),
        .ram_q     (ram_q),
        .m         (s_if),
        .busy      (busy),
        .done      (done)
`ifdef RAM_STREAM_READER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] mem [0:65535];
    always @(posedge clk) ram_q <= mem[ram_addr];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int valid_cnt = 0;
    int done_cyc;
    int rdy_k = 0;
    logic ready_mode = 1'b0;
    logic log_addr = 1'b0;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic [3:0] rdy_pat = 4'b1001;
    exp_t e;
    exp_t sb [$];
    int xfer_cyc [$];
    logic [15:0] addr_log [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sink ready: held high, or cycling 1,0,0,1 when ready_mode is set
    always @(posedge clk) begin
        #1;
        if (ready_mode) begin
            s_if.m_ready = rdy_pat[rdy_k];
            rdy_k = (rdy_k + 1) % 4;
        end else begin
            s_if.m_ready = 1'b1;
            rdy_k = 0;
        end
    end

    // Output monitor: scoreboard compare, stall stability, activity counters
    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (s_if.m_valid) valid_cnt++;
        if (log_addr && busy && (addr_log.size() == 0 || addr_log[$] != ram_addr))
            addr_log.push_back(ram_addr);
        if (prev_stall) begin
            check("stall_valid", s_if.m_valid, 1);
            check("stall_data", s_if.m_data, prev_data);
        end
        prev_stall = s_if.m_valid && !s_if.m_ready;
        prev_data  = s_if.m_data;
        if (s_if.m_valid && s_if.m_ready) begin
            xfer_cyc.push_back(cyc);
            check("sb_has_entry", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("byte_data", s_if.m_data, e.data);
                check("byte_last", s_if.m_last, e.last);
            end
        end
    end

    task automatic run_burst(input logic [15:0] base, input logic [15:0] n);
        logic [15:0] a;
        for (int i = 0; i < int'(n); i++) begin
            a = base + 16'(i);
            sb.push_back('{data: mem[a], last: (i == int'(n) - 1)});
        end
        xfer_cyc.delete();
        @(posedge clk);
        #1;
        start = 1'b1;
        base_addr = base;
        len = n;
        @(posedge clk);
        #1;
        start = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output int dc);
        dc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) begin
                dc = cyc;
                break;
            end
        end
        check("done_seen", dc >= 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = i[7:0];
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = 16'h0;
        len = 16'h0;
        s_if.m_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ram_addr", ram_addr, 16'h0000);
        check("rst_m_valid", s_if.m_valid, 0);
        check("rst_m_last", s_if.m_last, 0);
        check("rst_m_data", s_if.m_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic burst: 0x10..0x13 back to back, done right after the last byte
        run_burst(16'h0010, 16'd4);
        wait_done(40, done_cyc);
        check("t1_count", xfer_cyc.size(), 4);
        for (int i = 0; i < 4; i++) check("t1_xfer_cyc", xfer_cyc[i], start_cyc + 2 + i);
        check("t1_done_cyc", done_cyc, start_cyc + 6);
        check("t1_sb_empty", sb.size(), 0);
        @(negedge clk);
        check("t1_done_pulse", done, 0);
        check("t1_idle", busy, 0);

        // Address wrap across 0xFFFF
        addr_log.delete();
        log_addr = 1'b1;
        run_burst(16'hFFFE, 16'd4);
        wait_done(40, done_cyc);
        log_addr = 1'b0;
        check("t2_addr_n", addr_log.size(), 4);
        check("t2_addr0", addr_log[0], 16'hFFFE);
        check("t2_addr1", addr_log[1], 16'hFFFF);
        check("t2_addr2", addr_log[2], 16'h0000);
        check("t2_addr3", addr_log[3], 16'h0001);
        check("t2_count", xfer_cyc.size(), 4);

        // Back-pressure 1,0,0,1
        ready_mode = 1'b1;
        run_burst(16'h0100, 16'd8);
        wait_done(100, done_cyc);
        ready_mode = 1'b0;
        check("t3_count", xfer_cyc.size(), 8);
        check("t3_sb_empty", sb.size(), 0);

        // Zero length: done only, busy one cycle, no bytes
        @(posedge clk);
        #1;
        busy_cnt = 0;
        valid_cnt = 0;
        run_burst(16'h0050, 16'd0);
        wait_done(10, done_cyc);
        check("t4_done_cyc", done_cyc, start_cyc);
        repeat (3) @(negedge clk);
        check("t4_busy_cycles", busy_cnt, 1);
        check("t4_no_valid", valid_cnt, 0);

        // Reset after the third byte of a len=10 burst
        run_burst(16'h0030, 16'd10);
        done_cyc = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (xfer_cyc.size() >= 3) begin
                done_cyc = i;
                break;
            end
        end
        check("t5_third_byte_seen", done_cyc >= 0, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        done_cnt = 0;
        @(negedge clk);
        check("t5_valid_off", s_if.m_valid, 0);
        check("t5_idle", busy, 0);
        check("t5_ram_addr", ram_addr, 16'h0000);
        sb.delete();
        repeat (6) @(negedge clk);
        check("t5_no_done", done_cnt, 0);
        check("t5_no_valid", s_if.m_valid, 0);
        run_burst(16'h0040, 16'd3);
        wait_done(40, done_cyc);
        check("t5_restart_count", xfer_cyc.size(), 3);
        check("t5_restart_done_cyc", done_cyc, start_cyc + 5);

`ifdef RAM_STREAM_READER_CHECKSUM_EN
        // Checksum over three 0xFF bytes
        for (int i = 0; i < 3; i++) mem[16'h0200 + i] = 8'hFF;
        run_burst(16'h0200, 16'd3);
        wait_done(40, done_cyc);
        check("t6_checksum", checksum, 16'h02FD);
`endif

        repeat (2) @(negedge clk);
        check("final_sb_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
